// File: rtl/led_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : led_stream_rx
// Function : LED-chain serial receiver; rebuilds channel words and checks
//            the frame length at every latch.
// Revision : 1.0
// ============================================================================
module led_stream_rx #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sclk,
  input  logic                i_sdi,
  input  logic                i_lat,
  output logic                o_wr_en,
  output logic [c_addr_w-1:0] o_wr_addr,
  output logic [c_bpc-1:0]    o_wr_data,
  output logic                o_frame_done,
  output logic                o_frame_err
);

  localparam int                  c_bcnt_w   = $clog2(c_bpc);
  localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(c_bpc - 1);
  localparam logic [c_addr_w:0]   c_full     = (c_addr_w + 1)'(c_channels);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_OVF   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_sdi_s1,  r_sdi_s2;
  logic r_lat_s1,  r_lat_s2,  r_lat_s3;

  logic [c_bpc-2:0]    r_shreg;
  logic [c_bcnt_w-1:0] r_bitcnt;
  logic [c_addr_w:0]   r_wordcnt;

  logic             w_sclk_rise;
  logic             w_lat_rise;
  logic             w_word_done;
  logic             w_wr_fire;
  logic             w_done_fire;
  logic             w_err_fire;
  logic [c_bpc-1:0] w_shift_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_sdi_s1  <= 1'b0;
      r_sdi_s2  <= 1'b0;
      r_lat_s1  <= 1'b0;
      r_lat_s2  <= 1'b0;
      r_lat_s3  <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sdi_s1  <= i_sdi;
      r_sdi_s2  <= r_sdi_s1;
      r_lat_s1  <= i_lat;
      r_lat_s2  <= r_lat_s1;
      r_lat_s3  <= r_lat_s2;
    end
  end

  // A latch edge suppresses a coincident sclk edge entirely.
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_lat_rise  = r_lat_s2 & ~r_lat_s3;
  assign w_word_done = w_sclk_rise & ~w_lat_rise & (r_bitcnt == c_last_bit);
  assign w_shift_nxt = {r_shreg, r_sdi_s2};

  always_comb begin
    w_state_nxt = r_state;
    w_wr_fire   = 1'b0;
    w_done_fire = 1'b0;
    w_err_fire  = 1'b0;
    if (w_lat_rise) begin
      w_state_nxt = S_IDLE;
      if ((r_state != S_OVF) && (r_wordcnt == c_full) && (r_bitcnt == '0)) begin
        w_done_fire = 1'b1;
      end else begin
        w_err_fire = 1'b1;
      end
    end else if (w_sclk_rise) begin
      if (r_state == S_IDLE) begin
        w_state_nxt = S_SHIFT;
      end
      if ((r_state != S_OVF) && w_word_done) begin
        if (r_wordcnt == c_full) begin
          w_state_nxt = S_OVF;
        end else begin
          w_wr_fire = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word count only advances on an accepted write, so it saturates at c_channels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_wordcnt    <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_wr_en      <= w_wr_fire;
      o_frame_done <= w_done_fire;
      o_frame_err  <= w_err_fire;
      if (w_lat_rise) begin
        r_shreg   <= '0;
        r_bitcnt  <= '0;
        r_wordcnt <= '0;
      end else if (w_sclk_rise) begin
        r_shreg <= w_shift_nxt[c_bpc-2:0];
        if (w_word_done) begin
          r_bitcnt <= '0;
        end else begin
          r_bitcnt <= r_bitcnt + c_bcnt_w'(1);
        end
        if (w_wr_fire) begin
          o_wr_data <= w_shift_nxt;
          o_wr_addr <= r_wordcnt[c_addr_w-1:0];
          r_wordcnt <= r_wordcnt + (c_addr_w + 1)'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_stream_rx
// Function : Scoreboard bench for led_stream_rx (32 channels, 12-bit words).
// Revision : 1.0
// ============================================================================
module tb_led_stream_rx;

  localparam int c_ch  = 32;
  localparam int c_bpc = 12;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        sdi;
  logic        lat;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [16:0] wq[$];
  logic        fq[$];

  int          m_words;
  int          m_bits;
  logic        m_ovf;
  logic [11:0] m_shreg;

  led_stream_rx #(
    .c_ledboards(1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sclk      (sclk),
    .i_sdi       (sdi),
    .i_lat       (lat),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_frame_done(frame_done),
    .o_frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%03h expected none", wr_addr, wr_data);
      end else begin
        logic [16:0] e;
        e = wq.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write addr=%0d data=%03h expected addr=%0d data=%03h",
                   wr_addr, wr_data, e[16:12], e[11:0]);
        end
      end
    end
    if (frame_done || frame_err) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame done=%0b err=%0b expected none", frame_done, frame_err);
      end else begin
        logic ed;
        ed = fq.pop_front();
        if ({frame_done, frame_err} !== {ed, ~ed}) begin
          errors++;
          $display("FAIL frame done=%0b err=%0b expected done=%0b err=%0b",
                   frame_done, frame_err, ed, ~ed);
        end
      end
      checks++;
      if (wr_en || (frame_done && frame_err)) begin
        errors++;
        $display("FAIL exclusive wr=%0b done=%0b err=%0b expected at most one", wr_en, frame_done, frame_err);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_clear();
    m_words = 0;
    m_bits  = 0;
    m_ovf   = 1'b0;
    m_shreg = '0;
  endfunction

  function automatic void model_bit(input logic b);
    m_shreg = {m_shreg[10:0], b};
    if (m_bits == c_bpc - 1) begin
      m_bits = 0;
      if (!m_ovf && m_words < c_ch) begin
        wq.push_back({m_words[4:0], m_shreg});
        m_words++;
      end else begin
        m_ovf = 1'b1;
      end
    end else begin
      m_bits++;
    end
  endfunction

  task automatic send_bit(input logic b, input int gap);
    sdi = b;
    cycles(4);
    sclk = 1'b1;
    model_bit(b);
    cycles(4);
    sclk = 1'b0;
    cycles(gap);
  endtask

  task automatic send_word(input logic [11:0] w, input int gapmax);
    for (int i = 11; i >= 0; i--) begin
      send_bit(w[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || fq.size() != 0) && n < 200) begin
      cycles(1);
      n++;
    end
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain pending_writes=%0d pending_frames=%0d expected 0 0", wq.size(), fq.size());
      wq.delete();
      fq.delete();
    end
  endtask

  task automatic do_latch();
    fq.push_back(!m_ovf && m_words == c_ch && m_bits == 0);
    model_clear();
    lat = 1'b1;
    cycles(6);
    lat = 1'b0;
    cycles(2);
    drain();
  endtask

  task automatic send_frame(input int nwords, input logic [11:0] base, input int gapmax);
    for (int k = 0; k < nwords; k++) begin
      send_word(base + 12'(k), gapmax);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, frame_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%05h expected 00000", {wr_en, wr_addr, wr_data, frame_done, frame_err});
    end
    do_latch();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    rst_n = 1'b0;
    model_clear();
    cycles(2);
    checks++;
    if ({wr_en, frame_done, frame_err} !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_word got=%03b expected 000", {wr_en, frame_done, frame_err});
    end
    rst_n = 1'b1;
    cycles(2);
    send_frame(c_ch, 12'h100, 0);
    do_latch();
  endtask

  task automatic test_full_frame();
    send_frame(c_ch, 12'h000, 0);
    do_latch();
  endtask

  task automatic test_msb_order();
    logic [11:0] w;
    w = 12'hA5C;
    for (int i = 11; i >= 1; i--) send_bit(w[i], 0);
    sdi = w[0];
    cycles(4);
    sclk = 1'b1;
    model_bit(w[0]);
    cycles(2);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL latency_early wr_en=%0b expected 0", wr_en);
    end
    cycles(1);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 12'hA5C || wr_addr !== 5'd0) begin
      errors++;
      $display("FAIL latency wr_en=%0b data=%03h addr=%0d expected 1 a5c 0", wr_en, wr_data, wr_addr);
    end
    cycles(1);
    sclk = 1'b0;
    cycles(4);
    do_latch();
  endtask

  task automatic test_short_partial();
    send_frame(c_ch - 1, 12'h200, 0);
    do_latch();
    send_frame(c_ch, 12'h300, 0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 0);
    do_latch();
    send_frame(c_ch, 12'h400, 0);
    do_latch();
  endtask

  task automatic test_overflow();
    send_frame(c_ch + 1, 12'h500, 0);
    do_latch();
  endtask

  task automatic test_gaps_collision();
    send_frame(c_ch, 12'h000, 20);
    do_latch();
    send_frame(3, 12'h600, 0);
    for (int i = 0; i < 11; i++) send_bit(1'b1, 0);
    sdi = 1'b1;
    cycles(4);
    fq.push_back(1'b0);
    model_clear();
    sclk = 1'b1;
    lat  = 1'b1;
    cycles(4);
    sclk = 1'b0;
    cycles(2);
    lat = 1'b0;
    cycles(2);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    sdi   = 1'b0;
    lat   = 1'b0;
    model_clear();
    cycles(1);
    test_reset();
    test_full_frame();
    test_msb_order();
    test_short_partial();
    test_overflow();
    test_gaps_collision();
    cycles(10);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL final_queues writes=%0d frames=%0d expected 0 0", wq.size(), fq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
